// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter: general-purpose register bank whose single write port
// is shared round-robin between ALU writeback (A) and memory-load return (B).
// Grants are combinational; a write commits on the next falling clock edge.
// The two read ports are combinational and do not bypass in-flight writes.
module reg_bank_write_arbiter #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 8
) (
    input  logic             inClk,
    input  logic             inClr,
    input  logic             inReqA,
    input  logic [AW-1:0]    inAddrA,
    input  logic [WIDTH-1:0] inDataA,
    output logic             outAckA,
    input  logic             inReqB,
    input  logic [AW-1:0]    inAddrB,
    input  logic [WIDTH-1:0] inDataB,
    output logic             outAckB,
    input  logic [AW-1:0]    inRdAddr0,
    output logic [WIDTH-1:0] outRdData0,
    input  logic [AW-1:0]    inRdAddr1,
    output logic [WIDTH-1:0] outRdData1,
    output logic [CNT_W-1:0] outConflicts
);

    localparam logic [AW:0] NREGS_L = (AW + 1)'(NREGS);

    // An address maps to real storage only if it is in range and is not the
    // hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < NREGS_L);
        is_zero  = (ZERO_REG != 0) && (a == {AW{1'b0}});
        return in_range && !is_zero;
    endfunction

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_ptr_b;      // 1: B wins the next conflict, 0: A wins
    logic [CNT_W-1:0] r_conflicts;

    logic             w_both;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;

    // Zero-latency grant: a lone request wins outright, a conflict goes to the pointer owner.
    always_comb begin
        w_both = inReqA & inReqB;
        if (inClr) begin
            outAckA = 1'b0;
            outAckB = 1'b0;
        end else begin
            outAckA = inReqA & (~inReqB | ~r_ptr_b);
            outAckB = inReqB & (~inReqA |  r_ptr_b);
        end
    end

    // Select the granted requester's address/data for the shared write port.
    always_comb begin
        if (outAckA) begin
            w_wr_addr = inAddrA;
            w_wr_data = inDataA;
        end else begin
            w_wr_addr = inAddrB;
            w_wr_data = inDataB;
        end
        w_wr_en = (outAckA | outAckB) & addr_ok(w_wr_addr);
    end

    // Combinational operand fetch; unmapped addresses read as zero.
    always_comb begin
        if (addr_ok(inRdAddr0)) begin
            outRdData0 = r_regs[inRdAddr0];
        end else begin
            outRdData0 = {WIDTH{1'b0}};
        end
        if (addr_ok(inRdAddr1)) begin
            outRdData1 = r_regs[inRdAddr1];
        end else begin
            outRdData1 = {WIDTH{1'b0}};
        end
    end

    // Register bank storage: commit the granted write on the falling edge.
    always_ff @(negedge inClk or posedge inClr) begin
        if (inClr) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    // Round-robin pointer hands priority to the loser; conflict counter saturates.
    always_ff @(negedge inClk or posedge inClr) begin
        if (inClr) begin
            r_ptr_b     <= 1'b0;
            r_conflicts <= {CNT_W{1'b0}};
        end else begin
            if (outAckA) begin
                r_ptr_b <= 1'b1;
            end else if (outAckB) begin
                r_ptr_b <= 1'b0;
            end
            if (w_both && (r_conflicts != {CNT_W{1'b1}})) begin
                r_conflicts <= r_conflicts + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign outConflicts = r_conflicts;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// tb_reg_bank_write_arbiter: scoreboard bench for the register bank arbiter.
// The stimulus process predicts each cycle's acks, read data and counter from
// a plain reference model and queues the prediction; a monitor on the rising
// edge (opposite to the falling update edge) pops and compares.
module tb_reg_bank_write_arbiter;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             inClk = 1'b0;
    logic             inClr;
    logic             inReqA, inReqB;
    logic [AW-1:0]    inAddrA, inAddrB, inRdAddr0, inRdAddr1;
    logic [WIDTH-1:0] inDataA, inDataB;
    logic             outAckA, outAckB;
    logic [WIDTH-1:0] outRdData0, outRdData1;
    logic [CNT_W-1:0] outConflicts;

    reg_bank_write_arbiter #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .ZERO_REG(1), .CNT_W(CNT_W)
    ) dut (
        .inClk(inClk), .inClr(inClr),
        .inReqA(inReqA), .inAddrA(inAddrA), .inDataA(inDataA), .outAckA(outAckA),
        .inReqB(inReqB), .inAddrB(inAddrB), .inDataB(inDataB), .outAckB(outAckB),
        .inRdAddr0(inRdAddr0), .outRdData0(outRdData0),
        .inRdAddr1(inRdAddr1), .outRdData1(outRdData1),
        .outConflicts(outConflicts)
    );

    always #5 inClk = ~inClk;

    typedef struct {
        logic             ack_a;
        logic             ack_b;
        logic [WIDTH-1:0] rd0;
        logic [WIDTH-1:0] rd1;
        logic [CNT_W-1:0] conf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: register contents, who won most recently, conflict count.
    int m_regs[NREGS];
    int m_last;   // -1 none since reset, 0 = A won last, 1 = B won last
    int m_conf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_read(input logic [AW-1:0] a);
        if (a == 0 || a >= NREGS) return 0;
        return m_regs[a];
    endfunction

    task automatic m_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        if (a != 0 && a < NREGS) m_regs[a] = int'(d);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_last = -1;
        m_conf = 0;
    endtask

    // Predict this cycle, queue it, then apply the falling-edge commit to the model.
    task automatic issue(output logic g_a, output logic g_b);
        exp_t e;
        g_a = inReqA && (!inReqB || m_last != 0);
        g_b = inReqB && !g_a;
        e.ack_a = g_a;
        e.ack_b = g_b;
        e.rd0   = WIDTH'(m_read(inRdAddr0));
        e.rd1   = WIDTH'(m_read(inRdAddr1));
        e.conf  = CNT_W'(m_conf);
        exp_q.push_back(e);
        @(negedge inClk);
        if (inReqA && inReqB && m_conf < CMAX) m_conf++;
        if (g_a) begin
            m_write(inAddrA, inDataA);
            m_last = 0;
        end else if (g_b) begin
            m_write(inAddrB, inDataB);
            m_last = 1;
        end
        #1;
    endtask

    // Monitor: compare the DUT against the queued prediction mid-cycle.
    always @(posedge inClk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ackA", 32'(outAckA), 32'(mon_e.ack_a));
            chk("ackB", 32'(outAckB), 32'(mon_e.ack_b));
            chk("rd0", 32'(outRdData0), 32'(mon_e.rd0));
            chk("rd1", 32'(outRdData1), 32'(mon_e.rd1));
            chk("conflicts", 32'(outConflicts), 32'(mon_e.conf));
        end
    end

    // Asynchronous reset asserted mid-cycle with both requests pending.
    task automatic mid_reset();
        inReqA = 1'b1; inAddrA = 3'd4; inDataA = 16'h5A5A;
        inReqB = 1'b1; inAddrB = 3'd6; inDataB = 16'hA5A5;
        @(posedge inClk);
        #2;
        inClr = 1'b1;
        #1;
        chk("rst_ackA", 32'(outAckA), 32'd0);
        chk("rst_ackB", 32'(outAckB), 32'd0);
        chk("rst_conflicts", 32'(outConflicts), 32'd0);
        for (int a = 0; a < NREGS; a++) begin
            inRdAddr0 = AW'(a);
            inRdAddr1 = AW'(NREGS - 1 - a);
            #1;
            chk("rst_rd0", 32'(outRdData0), 32'd0);
            chk("rst_rd1", 32'(outRdData1), 32'd0);
        end
        @(negedge inClk);
        #1;
        inReqA = 1'b0;
        inReqB = 1'b0;
        inClr  = 1'b0;
        m_reset();
    endtask

    // Random traffic: each requester holds its transaction until acked.
    task automatic random_phase(input int cycles);
        logic g_a, g_b;
        for (int c = 0; c < cycles; c++) begin
            if (!inReqA && $urandom_range(0, 99) < 60) begin
                inReqA = 1'b1; inAddrA = AW'($urandom); inDataA = WIDTH'($urandom);
            end
            if (!inReqB && $urandom_range(0, 99) < 60) begin
                inReqB = 1'b1; inAddrB = AW'($urandom); inDataB = WIDTH'($urandom);
            end
            inRdAddr0 = AW'($urandom);
            inRdAddr1 = AW'($urandom);
            issue(g_a, g_b);
            if (g_a) inReqA = 1'b0;
            if (g_b) inReqB = 1'b0;
        end
        inReqA = 1'b0;
        inReqB = 1'b0;
    endtask

    // Both requesters held high for n edges with fresh data after every ack.
    task automatic sustained_conflict(input int n);
        logic g_a, g_b;
        inReqA = 1'b1; inAddrA = AW'($urandom_range(1, 7)); inDataA = WIDTH'($urandom);
        inReqB = 1'b1; inAddrB = AW'($urandom_range(1, 7)); inDataB = WIDTH'($urandom);
        for (int k = 0; k < n; k++) begin
            inRdAddr0 = AW'($urandom);
            inRdAddr1 = AW'($urandom);
            #1;
            chk("alt_ackA", 32'(outAckA), 32'((k % 2) == 0));
            chk("alt_ackB", 32'(outAckB), 32'((k % 2) == 1));
            issue(g_a, g_b);
            if (g_a) begin
                inAddrA = AW'($urandom_range(1, 7)); inDataA = WIDTH'($urandom);
            end
            if (g_b) begin
                inAddrB = AW'($urandom_range(1, 7)); inDataB = WIDTH'($urandom);
            end
        end
        inReqA = 1'b0;
        inReqB = 1'b0;
    endtask

    initial begin
        logic g_a, g_b;
        inClr = 1'b1;
        inReqA = 1'b0; inAddrA = '0; inDataA = '0;
        inReqB = 1'b0; inAddrB = '0; inDataB = '0;
        inRdAddr0 = '0; inRdAddr1 = '0;
        m_reset();
        repeat (2) @(negedge inClk);
        #1;
        inClr = 1'b0;

        // Load the bank, then reset mid-handshake.
        random_phase(120);
        mid_reset();

        // A alone to register 3: acked at once, visible only after the edge.
        inReqA = 1'b1; inAddrA = 3'd3; inDataA = 16'hBEEF; inRdAddr0 = 3'd3; inRdAddr1 = 3'd0;
        issue(g_a, g_b);
        inReqA = 1'b0;
        chk("t2_rd_after", 32'(outRdData0), 32'h0000BEEF);
        issue(g_a, g_b);

        // Simultaneous first requests after reset: A then B.
        mid_reset();
        inReqA = 1'b1; inAddrA = 3'd1; inDataA = 16'h1111;
        inReqB = 1'b1; inAddrB = 3'd2; inDataB = 16'h2222;
        issue(g_a, g_b);
        inReqA = 1'b0;
        issue(g_a, g_b);
        inReqB = 1'b0;
        inRdAddr0 = 3'd1; inRdAddr1 = 3'd2;
        #1;
        chk("t3_reg1", 32'(outRdData0), 32'h00001111);
        chk("t3_reg2", 32'(outRdData1), 32'h00002222);
        chk("t3_conflicts", 32'(outConflicts), 32'd1);
        issue(g_a, g_b);

        // Four sustained conflict edges, then same-address race: loser wins.
        mid_reset();
        sustained_conflict(4);
        chk("t4_conflicts", 32'(outConflicts), 32'd4);
        inReqA = 1'b1; inAddrA = 3'd5; inDataA = 16'hAAAA;
        inReqB = 1'b1; inAddrB = 3'd5; inDataB = 16'hBBBB;
        issue(g_a, g_b);
        inReqA = 1'b0;
        issue(g_a, g_b);
        inReqB = 1'b0;
        inRdAddr0 = 3'd5;
        #1;
        chk("t4_same_addr", 32'(outRdData0), 32'h0000BBBB);
        issue(g_a, g_b);

        // Write to the zero register: acked, discarded.
        inReqA = 1'b1; inAddrA = 3'd0; inDataA = 16'h1234; inRdAddr0 = 3'd0;
        #1;
        chk("t5_ack", 32'(outAckA), 32'd1);
        issue(g_a, g_b);
        inReqA = 1'b0;
        chk("t5_rd0", 32'(outRdData0), 32'd0);
        issue(g_a, g_b);

        // Counter saturation under 300 conflict edges.
        mid_reset();
        sustained_conflict(300);
        chk("t6_conflicts", 32'(outConflicts), 32'(CMAX));

        random_phase(150);
        @(negedge inClk);
        #1;
        if (exp_q.size() != 0) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
